aes_block_sequencer: RTL and testbench

- Cycle-level controller for the iterative AES engine inside the HWPE.
- On a start command it performs these steps in order:
  - triggers key expansion;
  - for each of N blocks: accepts one 128-bit input block from the source streamer, steps the engine through Nr rounds, then hands the result to the sink streamer.
- Sits between the main controller FSM (which issues start/clear and receives done) and the engine and streamer handshakes. It carries no data itself.

---
 rtl/aes_block_sequencer.sv | 171 +++++++++++++++++
 tb/tb_aes_block_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aes_block_sequencer.sv
// Cycle-level sequencer for the iterative AES engine: key expansion,
// then per-block load / Nr rounds / store handshakes. Carries no data.
module aes_block_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int RND_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] nb_blocks_i,
  input  logic [1:0]           key_size_i,
  output logic                 key_exp_start_o,
  input  logic                 key_exp_done_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 eng_load_o,
  output logic                 eng_round_en_o,
  output logic [RND_WIDTH-1:0] eng_round_idx_o,
  output logic                 eng_final_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] blk_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] nb_q, nb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [RND_WIDTH-1:0] nr_q, nr_d;
  logic [RND_WIDTH-1:0] rnd_q, rnd_d;
  logic [RND_WIDTH-1:0] nr_sel;
  logic                 kx_first_q, kx_first_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 key_ok;
  logic                 rnd_last;

  logic st_idle, st_keyexp, st_load;
  logic st_round, st_store, st_done;

  assign st_idle   = (state_q == S_IDLE);
  assign st_keyexp = (state_q == S_KEYEXP);
  assign st_load   = (state_q == S_LOAD);
  assign st_round  = (state_q == S_ROUND);
  assign st_store  = (state_q == S_STORE);
  assign st_done   = (state_q == S_DONE);

  always_comb begin
    nr_sel = '0;
    unique case (key_size_i)
      2'd0:    nr_sel = RND_WIDTH'(10);
      2'd1:    nr_sel = RND_WIDTH'(12);
      2'd2:    nr_sel = RND_WIDTH'(14);
      default: nr_sel = '0;
    endcase
  end

  assign key_ok   = (key_size_i != 2'd3);
  assign rnd_last = (rnd_q == nr_q);
  assign cnt_inc  = cnt_q + 1'b1;

  // cnt_q < nb_q holds inside a job, so cnt_inc cannot wrap
  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    nr_d       = nr_q;
    cnt_d      = cnt_q;
    rnd_d      = rnd_q;
    kx_first_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rnd_d   = '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (start_i) begin
            if (!key_ok) begin
              err_d = 1'b1;
            end else if (nb_blocks_i == '0) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              nb_d       = nb_blocks_i;
              nr_d       = nr_sel;
              cnt_d      = '0;
              kx_first_d = 1'b1;
              state_d    = S_KEYEXP;
            end
          end
        end
        st_keyexp: begin
          if (key_exp_done_i) state_d = S_LOAD;
        end
        st_load: begin
          if (in_valid_i) begin
            rnd_d   = RND_WIDTH'(1);
            state_d = S_ROUND;
          end
        end
        st_round: begin
          if (rnd_last) begin
            rnd_d   = '0;
            state_d = S_STORE;
          end else begin
            rnd_d = rnd_q + 1'b1;
          end
        end
        st_store: begin
          if (out_ready_i) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == nb_q) ? S_DONE : S_LOAD;
          end
        end
        st_done: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      nb_q       <= '0;
      nr_q       <= '0;
      cnt_q      <= '0;
      rnd_q      <= '0;
      kx_first_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      nr_q       <= nr_d;
      cnt_q      <= cnt_d;
      rnd_q      <= rnd_d;
      kx_first_q <= kx_first_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign key_exp_start_o = st_keyexp & kx_first_q;
  assign in_ready_o      = st_load;
  assign eng_load_o      = st_load & in_valid_i;
  assign eng_round_en_o  = st_round;
  assign eng_round_idx_o = st_round ? rnd_q : '0;
  assign eng_final_o     = st_round & rnd_last;
  assign out_valid_o     = st_store;
  assign blk_cnt_o       = cnt_q;
  assign busy_o          = ~st_idle;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: job table plus
// clear / async-reset sequences, with a block-count scoreboard.
module tb_aes_block_sequencer;

  localparam int CW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] nb = '0;
  logic [1:0]    ks = '0;
  logic          kx_done = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          kx_start, in_ready, eng_load, round_en;
  logic [RW-1:0] round_idx;
  logic          eng_final, out_valid, busy, done, err;
  logic [CW-1:0] blk_cnt;

  aes_block_sequencer #(.CNT_WIDTH(CW), .RND_WIDTH(RW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .nb_blocks_i     (nb),
    .key_size_i      (ks),
    .key_exp_start_o (kx_start),
    .key_exp_done_i  (kx_done),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .eng_load_o      (eng_load),
    .eng_round_en_o  (round_en),
    .eng_round_idx_o (round_idx),
    .eng_final_o     (eng_final),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .blk_cnt_o       (blk_cnt),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] ks;
    int nb, kxd, stall_blk, stall_len, busy_start, clr_blk, rst_blk;
    int exp_err, exp_kx, exp_nr, exp_blocks, exp_ov;
    int exp_done, exp_lat, exp_busy;
  } vec_t;

  task automatic run_job(input vec_t v, input string tag);
    int cyc = 0, kx_n = 0, kx_at = -1, err_n = 0, err_at = -1;
    int done_n = 0, done_at = -1, busy_n = 0, ov_tot = 0, ov_blk = 0;
    int loads = 0, hs = 0, rnd_exp = 0, rnd_blk = 0, viol = 0;
    int tail = -1, pend = 0, pend_exp = 0, do_clr = 0, clr_prev = 0;
    int sb[$];
    @(posedge clk); #1;
    start = 1'b1; ks = v.ks; nb = CW'(v.nb);
    in_valid = 1'b1; out_ready = 1'b1; kx_done = 1'b0; clear = 1'b0;
    @(negedge clk);
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start     = (cyc == v.busy_start);
      ks        = 2'(cyc);
      nb        = CW'(cyc * 7 + 2);
      kx_done   = (kx_at >= 0 && cyc == kx_at + v.kxd);
      out_ready = !(hs + 1 == v.stall_blk && ov_blk < v.stall_len);
      clear     = do_clr[0];
      do_clr    = 0;
      @(negedge clk);
      if (pend != 0) chk({tag, "_blk_cnt"}, 64'(blk_cnt), 64'(pend_exp));
      pend = 0;
      if (clr_prev != 0)
        chk({tag, "_post_clear"}, 64'({busy, blk_cnt, round_idx}), 64'(0));
      clr_prev = int'(clear);
      if (clear) chk({tag, "_clear_idx"}, 64'(round_idx), 64'(5));
      if (kx_start) begin kx_n++; kx_at = cyc; end
      if (err) begin err_n++; err_at = cyc; end
      if (done) begin
        done_n++; done_at = cyc;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      end
      if (busy) busy_n++;
      if (in_ready && out_valid) viol++;
      if (round_en && (in_ready || out_valid)) viol++;
      if (eng_load !== (in_ready && in_valid)) viol++;
      if (!busy && (in_ready || out_valid || round_en || kx_start)) viol++;
      if (in_ready && in_valid) begin
        loads++; sb.push_back(loads); rnd_exp = 1; rnd_blk = 0;
      end
      if (round_en) begin
        if (round_idx != RW'(rnd_exp) ||
            eng_final != (rnd_exp == v.exp_nr)) viol++;
        if (v.clr_blk == loads && round_idx == RW'(4)) do_clr = 1;
        rnd_exp++; rnd_blk++;
      end
      if (out_valid) begin
        ov_tot++;
        if (v.rst_blk == hs + 1) begin
          #2 rst_n = 1'b0;
          #1 chk({tag, "_rst_outputs"},
                 64'({kx_start, in_ready, eng_load, round_en, round_idx,
                      eng_final, out_valid, blk_cnt, busy, done, err}),
                 64'(0));
          tail = cyc;
        end else begin
          ov_blk++;
          if (out_ready) begin
            hs++;
            chk({tag, "_rounds"}, 64'(rnd_blk), 64'(v.exp_nr));
            pend_exp = (sb.size() > 0) ? sb.pop_front() : -1;
            pend = 1; ov_blk = 0;
          end
        end
      end
      if (tail < 0 && (done_n > 0 || err_n > 0 || clear)) tail = cyc;
      if (tail >= 0 && cyc >= tail + 3) break;
      if (cyc > 700) begin
        errors++; checks++;
        $display("FAIL %s_timeout: got cycle %0d expected completion", tag, cyc);
        break;
      end
    end
    start = 1'b0; clear = 1'b0;
    if (!rst_n) begin @(posedge clk); #1 rst_n = 1'b1; end
    chk({tag, "_err"}, 64'(err_n), 64'(v.exp_err));
    chk({tag, "_kx_start"}, 64'(kx_n), 64'(v.exp_kx));
    chk({tag, "_done"}, 64'(done_n), 64'(v.exp_done));
    chk({tag, "_blocks"}, 64'(hs), 64'(v.exp_blocks));
    chk({tag, "_ov_cycles"}, 64'(ov_tot), 64'(v.exp_ov));
    chk({tag, "_violations"}, 64'(viol), 64'(0));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(v.exp_busy));
    if (v.exp_done != 0) chk({tag, "_done_lat"}, 64'(done_at), 64'(v.exp_lat));
    if (v.exp_err != 0) chk({tag, "_err_lat"}, 64'(err_at), 64'(1));
    if (v.exp_done != 0 && v.exp_blocks > 0)
      chk({tag, "_final_cnt"}, 64'(blk_cnt), 64'(v.exp_blocks));
  endtask

  vec_t vt[10];

  initial begin
    //        ks nb kxd sb sl bs cb rb err kx nr blk ov dn lat busy
    vt[0] = '{2'd0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 10, 1, 1, 1, 17, 16};
    vt[1] = '{2'd2, 3, 1, 2, 5, 0, 0, 0, 0, 1, 14, 3, 8, 1, 57, 56};
    vt[2] = '{2'd3, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 1, 2, 1};
    vt[4] = '{2'd1, 2, 4, 0, 0, 8, 0, 0, 0, 1, 12, 2, 2, 1, 35, 34};
    vt[5] = '{2'd3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{2'd0, 4, 1, 0, 0, 0, 2, 0, 0, 1, 10, 1, 1, 0, 0, 20};
    vt[7] = '{2'd1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 12, 1, 1, 1, 20, 19};
    vt[8] = '{2'd0, 3, 1, 0, 0, 5, 0, 2, 0, 1, 10, 1, 2, 0, 0, 26};
    vt[9] = '{2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 10, 1, 1, 1, 16, 15};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({kx_start, in_ready, eng_load, round_en, round_idx,
             eng_final, out_valid, blk_cnt, busy, done, err}), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_job(vt[i], $sformatf("job%0d", i));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
